register_8bit: RTL and testbench
================================

// Module: register_8bit
//
// PURPOSE
//   General-purpose 8-bit data-path register with a clock enable.
//   - Captures an input byte on the rising clock edge when enabled.
//   - Otherwise holds its value.
//   - Used throughout the soft-processor datapath: accumulators, operand
//     latches and other state-holding registers.
//   - Output is purely registered; there is no combinational path from di to DO.
//
// PARAMETERS
//   WIDTH        8      data width in bits; all data ports use this width
//   RESET_VALUE  8'h00  value loaded into DO (WIDTH bits) on reset
//
// PORTS
//   clk     in   1      system clock; all state changes on the rising edge
//   rst_n   in   1      reset, synchronous, active-low
//   ce      in   1      clock enable / load strobe, active-high
//   di      in   WIDTH  data input
//   DO      out  WIDTH  registered data output
//   loaded  out  1      high for exactly one cycle after each cycle in which
//                       a load occurred
//   parity  out  1      even parity (XOR) of DO; present only with
//                       REGISTER_8BIT_PARITY_EN
//
// BEHAVIOUR
//   - One clock (clk). Reset is synchronous and active-low (rst_n), sampled
//     on the rising edge of clk.
//   - Reset (rst_n=0 at edge):
//       DO <= RESET_VALUE, loaded <= 0, parity <= ^RESET_VALUE.
//       Reset has priority over ce.
//   - Load (rst_n=1, ce=1 at edge):
//       DO <= di, loaded <= 1.
//       Latency: one edge; the new value is visible just after that edge.
//   - Hold (rst_n=1, ce=0 at edge):
//       DO keeps its value, loaded <= 0.
//       Changes on di while ce=0 never reach DO.
//   - ce held high on consecutive edges: DO follows di once per cycle, and
//     loaded stays high.
//   - Reset mid-operation: the reset edge overrides any concurrent load. The
//     first load can occur on the first edge with rst_n=1.
//   - Before the first reset edge, DO is undefined (X in simulation).
//     Integrators must assert rst_n for at least one edge.
//   - There is no asynchronous behaviour and no gating of clk; the enable is
//     implemented as a data-path mux or flop enable.
//   - No arithmetic is performed; widths of di and DO must match (WIDTH).
//
// CONFIGURATION
//   REGISTER_8BIT_PARITY_EN
//     defined:
//       - Adds output port parity.
//       - parity is registered; it updates on the same edge as DO and equals
//         ^DO at all times after reset.
//     undefined:
//       - parity port and its flop are absent.
//       - All other behaviour is identical.
//
// TESTING
//   clk period 20 ns; reset with rst_n=0 for 2 edges first.
//   1. Reset: rst_n=0, ce=1, di=8'hFF
//        -> DO=RESET_VALUE (0), loaded=0 after the edge.
//   2. Load: rst_n=1, ce=1, di=17 for 2 edges
//        -> DO=17, loaded=1.
//   3. Hold: ce=0, di=33 for 2 edges
//        -> DO stays 17, loaded=0 from the first hold edge.
//   4. Reload: ce=1, di=89
//        -> DO=89 after one edge, loaded=1; toggle di each cycle with ce=1
//           -> DO tracks with 1-cycle lag.
//   5. Reset vs load: rst_n=0, ce=1, di=8'hA5 on the same edge
//        -> DO=0, loaded=0.
//   6. PARITY_EN build: di=8'h07 loaded -> parity=1; di=8'h03 loaded -> parity=0.

Source files
------------

// File: rtl/register_8bit.sv
// 8-bit data-path register with clock enable and a one-cycle load strobe.
// Optional registered even-parity output enabled by REGISTER_8BIT_PARITY_EN.
module register_8bit #(
  parameter int unsigned          WIDTH       = 8,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] di,
  output logic [WIDTH-1:0] DO,
  output logic             loaded
`ifdef REGISTER_8BIT_PARITY_EN
  ,
  output logic             parity
`endif
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             loaded_q, loaded_d;

  always_comb begin
    data_d   = data_q;
    loaded_d = 1'b0;
    if (ce) begin
      data_d   = di;
      loaded_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q   <= RESET_VALUE;
      loaded_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      loaded_q <= loaded_d;
    end
  end

  assign DO     = data_q;
  assign loaded = loaded_q;

`ifdef REGISTER_8BIT_PARITY_EN
  logic parity_q;

  // Parity is computed from the next-state value so it lands on the same edge as DO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_q <= ^RESET_VALUE;
    end else begin
      parity_q <= ^data_d;
    end
  end

  assign parity = parity_q;
`endif

endmodule

// File: tb/tb_register_8bit.sv
// Self-checking bench for register_8bit: vector table plus a modelled random sequence,
// with expectations queued at drive time and popped after each edge.
module tb_register_8bit;

  localparam int unsigned WIDTH = 8;
  localparam logic [WIDTH-1:0] RV = 8'h00;

  logic             clk;
  logic             rst_n;
  logic             ce;
  logic [WIDTH-1:0] di;
  logic [WIDTH-1:0] DO;
  logic             loaded;
`ifdef REGISTER_8BIT_PARITY_EN
  logic             parity;
`endif

  register_8bit #(
    .WIDTH      (WIDTH),
    .RESET_VALUE(RV)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ce     (ce),
    .di     (di),
    .DO     (DO),
    .loaded (loaded)
`ifdef REGISTER_8BIT_PARITY_EN
    ,
    .parity (parity)
`endif
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    string            name;
    logic             rst_n;
    logic             ce;
    logic [WIDTH-1:0] di;
    logic [WIDTH-1:0] exp_do;
    logic             exp_loaded;
  } vec_t;

  typedef struct {
    string            name;
    logic [WIDTH-1:0] exp_do;
    logic             exp_loaded;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, queue the expectation, then compare 1 ns after the rising edge.
  task automatic apply(input string name, input logic r, input logic c,
                       input logic [WIDTH-1:0] d,
                       input logic [WIDTH-1:0] e_do, input logic e_ld);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst_n = r;
    ce    = c;
    di    = d;
    e.name = name;
    e.exp_do = e_do;
    e.exp_loaded = e_ld;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      got = sb.pop_front();
      check({got.name, ".DO"}, 32'(DO), 32'(got.exp_do));
      check({got.name, ".loaded"}, 32'(loaded), 32'(got.exp_loaded));
`ifdef REGISTER_8BIT_PARITY_EN
      check({got.name, ".parity"}, 32'(parity), 32'(^got.exp_do));
`endif
    end
  endtask

  vec_t vecs[13];

  initial begin
    #100us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [WIDTH-1:0] model_do;
    logic             r;
    logic             c;
    logic [WIDTH-1:0] d;

    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    ce    = 1'b0;
    di    = '0;

    vecs[0]  = '{"reset0",     1'b0, 1'b1, 8'hFF, 8'h00, 1'b0};
    vecs[1]  = '{"reset1",     1'b0, 1'b1, 8'hFF, 8'h00, 1'b0};
    vecs[2]  = '{"load17a",    1'b1, 1'b1, 8'd17, 8'd17, 1'b1};
    vecs[3]  = '{"load17b",    1'b1, 1'b1, 8'd17, 8'd17, 1'b1};
    vecs[4]  = '{"hold33a",    1'b1, 1'b0, 8'd33, 8'd17, 1'b0};
    vecs[5]  = '{"hold33b",    1'b1, 1'b0, 8'd33, 8'd17, 1'b0};
    vecs[6]  = '{"reload89",   1'b1, 1'b1, 8'd89, 8'd89, 1'b1};
    vecs[7]  = '{"track5A",    1'b1, 1'b1, 8'h5A, 8'h5A, 1'b1};
    vecs[8]  = '{"trackC3",    1'b1, 1'b1, 8'hC3, 8'hC3, 1'b1};
    vecs[9]  = '{"rst_vs_ld",  1'b0, 1'b1, 8'hA5, 8'h00, 1'b0};
    vecs[10] = '{"load07",     1'b1, 1'b1, 8'h07, 8'h07, 1'b1};
    vecs[11] = '{"load03",     1'b1, 1'b1, 8'h03, 8'h03, 1'b1};
    vecs[12] = '{"holdFF",     1'b1, 1'b0, 8'hFF, 8'h03, 1'b0};

    foreach (vecs[i])
      apply(vecs[i].name, vecs[i].rst_n, vecs[i].ce, vecs[i].di,
            vecs[i].exp_do, vecs[i].exp_loaded);

    // Full-width pattern just after a load, then long hold with a busy di.
    apply("loadFF", 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
    for (int i = 0; i < 4; i++)
      apply("holdbusy", 1'b1, 1'b0, 8'(i * 37 + 1), 8'hFF, 1'b0);

    // Random mix of reset, load and hold against a reference model.
    model_do = 8'hFF;
    for (int i = 0; i < 60; i++) begin
      r = ($urandom_range(0, 9) != 0);
      c = $urandom_range(0, 1) == 1;
      d = 8'($urandom);
      if (!r)     model_do = RV;
      else if (c) model_do = d;
      apply("random", r, c, d, model_do, r & c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
